// File: rtl/signed_addsub_pkg.sv
// Shared op encodings, default sizes and the signed-overflow rule for signed_addsub.
package signed_addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Overflow when the operand signs make a wrap possible and the result sign disagrees with A.
  function automatic logic ovf_detect(input logic op, input logic sign_a,
                                      input logic sign_b, input logic sign_r);
    logic signs_allow;
    signs_allow = (op == OP_SUB) ? (sign_a != sign_b) : (sign_a == sign_b);
    return signs_allow && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/signed_addsub_core.sv
// Combinational signed add/subtract with overflow detection.
// With SIGNED_ADDSUB_SAT_EN defined, overflowed results clamp to the nearest representable value.
module signed_addsub_core
  import signed_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] raw;

  always_comb begin
    raw = (op_i == OP_SUB) ? (a_i - b_i) : (a_i + b_i);
    ovf_o = ovf_detect(op_i, a_i[WIDTH-1], b_i[WIDTH-1], raw[WIDTH-1]);
`ifdef SIGNED_ADDSUB_SAT_EN
    // On overflow the true result always carries the sign of A.
    if (ovf_o) begin
      result_o = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      result_o = raw;
    end
`else
    result_o = raw;
`endif
  end

endmodule

// File: rtl/signed_addsub.sv
// Two-stage valid/ready signed adder/subtractor with a saturating overflow event counter.
// Optional saturation of results is enabled by defining SIGNED_ADDSUB_SAT_EN.
module signed_addsub
  import signed_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  logic             s2_load;
  logic             s1_load;
  logic [WIDTH-1:0] core_result;
  logic             core_ovf;

  signed_addsub_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (core_result),
    .ovf_o    (core_ovf)
  );

  // S1 may advance into S2 in the same cycle S2 drains, which gives full throughput.
  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    ovf_count_d = ovf_count_q;

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d  = a;
        b_d  = b;
        op_d = op;
      end
    end

    // Result and flag only change when a real beat lands, so they hold when idle.
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = core_result;
        ovf_d    = core_ovf;
      end
    end

    if (clr_count) begin
      ovf_count_d = '0;
    end else if (out_valid_q && out_ready && ovf_q && (ovf_count_q != {CNT_W{1'b1}})) begin
      ovf_count_d = ovf_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_signed_addsub.sv
// Scoreboard bench for signed_addsub: integer reference model, queue of expected beats,
// negedge monitor that checks outputs, backpressure stability and the overflow counter.
module tb_signed_addsub;

  localparam int W = 8;
  localparam int CW = 8;

  typedef struct {
    logic [W-1:0] r;
    logic         v;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          ovf;
  logic [CW-1:0] ovf_count;
  logic          clr_count;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  int   acc_cnt = 0;

  signed_addsub #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .ovf_count (ovf_count),
    .clr_count (clr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: exact integer arithmetic, overflow = true value outside the signed range.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mop);
    exp_t e;
    int sa, sb, t;
    logic [31:0] tv;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    t  = mop ? (sa - sb) : (sa + sb);
    tv = t;
    e.v = (t > 127) || (t < -128);
`ifdef SIGNED_ADDSUB_SAT_EN
    if (e.v) e.r = (t > 0) ? 8'h7F : 8'h80;
    else     e.r = tv[W-1:0];
`else
    e.r = tv[W-1:0];
`endif
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'h00;
      3: return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor / scoreboard
  initial begin : monitor
    logic         hold_prev;
    logic [W-1:0] held_r;
    logic         held_v;
    exp_t         e;
    logic         hs_ovf;
    hold_prev = 1'b0;
    held_r = '0;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_result", 32'(result), 32'(held_r));
          chk("hold_ovf", 32'(ovf), 32'(held_v));
        end
        chk("ovf_count", 32'(ovf_count), 32'(model_cnt));
        hs_ovf = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got result %0h with no beat outstanding at %0t", result, $time);
          end else begin
            e = exp_q.pop_front();
            hs_ovf = e.v;
            $display("beat result=%02h ovf=%0b (expected %02h/%0b)", result, ovf, e.r, e.v);
            chk("result", 32'(result), 32'(e.r));
            chk("ovf", 32'(ovf), 32'(e.v));
          end
        end
        if (clr_count) model_cnt = 0;
        else if (hs_ovf && model_cnt != 255) model_cnt++;
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a, b, op));
          acc_cnt++;
        end
        hold_prev = out_valid && !out_ready;
        held_r = result;
        held_v = ovf;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] ba, input logic [W-1:0] bb, input logic bop);
    in_valid = 1'b1;
    a = ba;
    b = bb;
    op = bop;
    cyc();
  endtask

  task automatic drain(input string nm);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stim
    int acc0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    op = 1'b0;
    out_ready = 1'b1;
    clr_count = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    cyc();

    // Latency: one beat into an empty pipe shows up two edges later.
    beat(8'h64, 8'h32, 1'b0);
    in_valid = 1'b0;
    chk("lat1_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("lat2_valid", 32'(out_valid), 32'd1);
    beat(8'h80, 8'h01, 1'b1);
    beat(8'h00, 8'h80, 1'b1);
    beat(8'hFB, 8'h03, 1'b0);
    drain("drain_directed");

    // Backpressure: only two beats fit with the output stalled.
    acc0 = acc_cnt;
    out_ready = 1'b0;
    repeat (4) beat(W'($urandom), W'($urandom), 1'($urandom));
    chk("bp_accepted", 32'(acc_cnt - acc0), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    drain("drain_bp");

    // Counter saturation after 300 overflowing beats.
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++)
      beat(W'($urandom_range(64, 127)), W'($urandom_range(64, 127)), 1'b0);
    drain("drain_sat");
    chk("cnt_saturated", 32'(ovf_count), 32'd255);

    // Clear coincident with an overflow handshake wins.
    beat(8'h64, 8'h32, 1'b0);
    in_valid = 1'b0;
    cyc();
    chk("clr_out_valid", 32'(out_valid), 32'd1);
    clr_count = 1'b1;
    cyc();
    clr_count = 1'b0;
    chk("clr_wins", 32'(ovf_count), 32'd0);

    // Random traffic with random backpressure and occasional clears.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      clr_count = ($urandom_range(0, 99) < 3);
      a  = pick();
      b  = pick();
      op = 1'($urandom);
      cyc();
    end
    clr_count = 1'b0;
    drain("drain_random");

    // Reset with two overflowing beats in flight.
    beat(8'h7F, 8'h01, 1'b0);
    beat(8'h80, 8'h7F, 1'b1);
    in_valid = 1'b0;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ovf_count", 32'(ovf_count), 32'd0);
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    beat(8'hFB, 8'h03, 1'b0);
    drain("drain_post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_addsub.md
SIGNED_ADDSUB -- requirements
Module: signed_addsub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (two's complement).
REQ-002 Parameter CNT_W, default 8, width of the overflow event counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-007 a  input  WIDTH  signed operand A.
REQ-008 b  input  WIDTH  signed operand B.
REQ-009 op  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result beat offered.
REQ-011 out_ready  input  1  result beat consumed when out_valid && out_ready.
REQ-012 result  output  WIDTH  signed result.
REQ-013 ovf  output  1  signed overflow flag for the current result beat.
REQ-014 ovf_count  output  CNT_W  saturating count of consumed beats with ovf=1.
REQ-015 clr_count  input  1  synchronous clear of ovf_count.

Function
REQ-016 Two-stage pipeline: S1 registers a/b/op; S2 registers result/ovf; latency exactly 2 cycles from input handshake to out_valid under no backpressure.
REQ-017 S2 loads when !out_valid || out_ready; S1 loads when S1 empty or S2 loads; in_ready = S1 load condition (combinational from out_ready permitted).
REQ-018 Full throughput: one beat per cycle sustained when out_ready=1.
REQ-019 Under backpressure (out_ready=0), result/ovf/out_valid hold stable; at most 2 beats buffered; no beat dropped, duplicated or reordered.
REQ-020 Arithmetic: result = low WIDTH bits of A+B or A-B (two's-complement wrap).
REQ-021 Add overflow: sign(A)==sign(B) && sign(result)!=sign(A).
REQ-022 Sub overflow: sign(A)!=sign(B) && sign(result)!=sign(A); covers B = most-negative value.
REQ-023 ovf_count increments on each output handshake with ovf=1; holds at all-ones (no wrap).
REQ-024 clr_count sets ovf_count to 0 next cycle; clear wins over a simultaneous increment (that event is not counted).
REQ-025 Output signals are don't-care-free: result and ovf hold last value when out_valid=0.

Reset
REQ-026 rst_n low asynchronously clears S1/S2 valid flags, result=0, ovf=0, ovf_count=0, out_valid=0; in_ready=1 while reset is deasserted and pipeline empty.
REQ-027 Reset mid-operation discards all in-flight beats; first post-reset output is from a beat accepted after reset release.

Configuration
REQ-028 Macro SIGNED_ADDSUB_SAT_EN defined: on overflow result saturates to max positive (e.g. 0x7F) when true sum is positive, most negative (e.g. 0x80) when negative; ovf still asserts and counts.
REQ-029 Macro undefined: result wraps per REQ-020; no saturation logic present.

Structure
REQ-030 Package signed_addsub_pkg holds op encodings OP_ADD=0/OP_SUB=1 and default WIDTH/CNT_W constants.
REQ-031 Sub-module signed_addsub_core: combinational result/ovf (and saturation under macro) instantiated between S1 and S2.

Verification
REQ-032 add 100+50 (0x64+0x32) -> 2 cycles later result=0x96, ovf=1; with SAT_EN result=0x7F.
REQ-033 sub -128-1 (0x80-0x01) -> result=0x7F, ovf=1; with SAT_EN result=0x80.
REQ-034 sub 0-(-128) (0x00-0x80) -> result=0x80, ovf=1; with SAT_EN 0x7F; add -5+3 -> 0xFE, ovf=0.
REQ-035 Continuous in_valid, out_ready=0 for 4 cycles -> exactly 2 beats accepted, in_ready=0 thereafter, output stable; release -> beats emerge in order, no loss.
REQ-036 300 consumed overflow beats, CNT_W=8 -> ovf_count=255; clr_count coincident with overflow handshake -> ovf_count=0.
REQ-037 rst_n pulsed low with 2 beats in flight -> out_valid=0, ovf_count=0 immediately; no stale beat emitted after release.
